spi_byte_master: RTL and testbench
==================================

// Module: spi_byte_master
//
// PURPOSE
//  Clocked SPI initiator: shifts one byte out on MOSI while shifting one in on MISO.
//  Counterpart to the byte-oriented SPI responders in CoreLogic.
//  Drives the serial RAM port (ram_nss/ram_sck/ram_mosi/ram_miso) and is reusable for
//  any CoreLogic-side master link. Mode 0, LSB first, matching the MCU/coprocessor buses.
//  Multi-byte transactions are supported by keeping NSS low between bytes.
//
// PARAMETERS
//  CLK_DIV     2   clk cycles per SCK half-period; legal range >= 1
//  BYTE_WIDTH  8   bits per transfer; default comes from `BYTE_WIDTH in defines.vh
//
// PORTS
//  clk       in   1           system clock; all logic is on the rising edge
//  reset     in   1           asynchronous, active-high reset
//  start     in   1           request a byte transfer; sampled only when idle or when done=1
//  last      in   1           sampled with start; 1 = release NSS after this byte
//  tx_data   in   BYTE_WIDTH  byte to send; sampled with start
//  busy      out  1           transfer in progress
//  done      out  1           one-cycle pulse; rx_data is valid from this cycle
//  rx_data   out  BYTE_WIDTH  last received byte; held until the next done
//  spi_nss   out  1           active-low slave select
//  spi_sck   out  1           serial clock; idles low
//  spi_mosi  out  1           serial data out
//  spi_miso  in   1           serial data in
//
// BEHAVIOUR
//  Reset values: spi_nss=1, spi_sck=0, spi_mosi=0, busy=0, done=0, rx_data=0.
//   Reset takes effect immediately, including mid-byte. No partial byte is reported.
//  States:
//   IDLE  NSS high; start=1 -> LOW, bit index=0.
//   LOW   sck=0, mosi=tx[idx]; after CLK_DIV cycles -> HIGH.
//   HIGH  sck=1; spi_miso is captured into rx_shift[idx] on the clk edge ending the
//         first HIGH cycle; after CLK_DIV cycles: idx<BYTE_WIDTH-1 -> idx++, LOW;
//         otherwise -> END.
//   END   single cycle: sck=0, done=1, busy=0, rx_data<=rx_shift.
//         last=1 -> spi_nss=1 this cycle, then IDLE.
//         last=0 -> spi_nss stays 0, then HOLD.
//   HOLD  NSS low, sck low; start=1 -> LOW; no timeout.
//  Timing, with start accepted at edge 0:
//   - edge 1: busy=1, spi_nss=0, spi_mosi=bit0.
//   - done=1 in cycle 2*BYTE_WIDTH*CLK_DIV+1.
//   - For CLK_DIV=2: done at cycle 33.
//  Back-to-back: start asserted in the END cycle is accepted; the next LOW phase begins
//   the following cycle. NSS never deasserts between bytes unless last=1.
//  start while busy: ignored; tx_data and last are not re-sampled.
//  MOSI changes only on SCK falling transitions or at transfer start, never while SCK=1.
//  last is only meaningful with start; a HOLD->IDLE release needs a final byte with last=1.
//
// STRUCTURE
//  Shared defines.vh: `BYTE_WIDTH and the state encodings (SPIM_IDLE/LOW/HIGH/END/HOLD).
//  One sub-module, spi_half_period_timer:
//   - $clog2(CLK_DIV)-bit down-counter with a tick output every CLK_DIV cycles.
//   - Reloads on phase entry.
//  This module holds the FSM, bit index, TX/RX shift registers and last latch.
//
// TESTING  (loopback spi_miso = ~spi_mosi unless noted; CLK_DIV=2)
//  1 Reset: outputs at reset values; assert reset mid-byte -> nss=1 and sck=0 that
//    cycle; no done.
//  2 Single byte: tx 0x29, last=1 -> mosi bits 1,0,0,1,0,1,0,0; rx_data=0xD6; done at
//    cycle 33; nss high in the same cycle.
//  3 Burst: 0x02,0x29,0x2A,0x32 with last only on the final byte ->
//    - nss low continuously;
//    - rx 0xFD,0xD6,0xD5,0xCD;
//    - each start is issued in the done cycle.
//  4 Busy ignore: start with tx 0xFF at cycle 10 of a 0x00 transfer -> rx_data=0xFF,
//    no second done.
//  5 HOLD: byte with last=0, idle 20 cycles -> nss low, sck low, busy=0; then 0x91
//    with last=1 -> rx 0x6E, nss rises.
//  6 CLK_DIV=1, miso tied to 1 -> rx_data=0xFF; done at cycle 17.

Source files
------------

// File: rtl/spi_byte_master_pkg.sv
// spi_byte_master_pkg: shared byte width, FSM state encoding and counter sizing for the SPI byte master
package spi_byte_master_pkg;

    localparam int SPIM_BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        SPIM_IDLE,
        SPIM_LOW,
        SPIM_HIGH,
        SPIM_END,
        SPIM_HOLD
    } spim_state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int spim_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_byte_master_timer.sv
// spi_byte_master_timer: SCK half-period down-counter; ports clk, reset, load (reload), tick (last cycle of phase), first (first cycle of phase)
module spi_byte_master_timer
    import spi_byte_master_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick,
    output logic first
);

    localparam int CW = spim_cnt_w(CLK_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= CW'(CLK_DIV - 1);
        else
            cnt <= load ? CW'(CLK_DIV - 1) : cnt - CW'(1);
    end

    assign tick  = cnt == '0;
    assign first = cnt == CW'(CLK_DIV - 1);

endmodule

// File: rtl/spi_byte_master.sv
// spi_byte_master: mode-0 LSB-first SPI initiator; ports clk/reset, start/last/tx_data request, busy/done/rx_data status, spi_nss/spi_sck/spi_mosi/spi_miso serial link
module spi_byte_master
    import spi_byte_master_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int BYTE_WIDTH = SPIM_BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  last,
    input  logic [BYTE_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [BYTE_WIDTH-1:0] rx_data,
    output logic                  spi_nss,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int IW = spim_cnt_w(BYTE_WIDTH);

    spim_state_t           state;
    logic [IW-1:0]         idx;
    logic [BYTE_WIDTH-1:0] tx_sh;
    logic [BYTE_WIDTH-1:0] rx_sh;
    logic [BYTE_WIDTH-1:0] rx_next;
    logic                  last_q;
    logic                  tick;
    logic                  first;
    logic                  in_phase;
    logic                  accept;

    assign in_phase = state == SPIM_LOW || state == SPIM_HIGH;
    assign accept   = start && !in_phase;
    // MISO enters at the top so that after a full byte bit 0 sits at the LSB.
    assign rx_next  = (state == SPIM_HIGH && first) ? {spi_miso, rx_sh[BYTE_WIDTH-1:1]} : rx_sh;

    // Outside the shifting phases the timer is held at its reload value, so a
    // new LOW phase starts with a full half-period.
    spi_byte_master_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tick || !in_phase),
        .tick  (tick),
        .first (first)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SPIM_IDLE;
            idx      <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            last_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            spi_nss  <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state    <= SPIM_LOW;
                idx      <= '0;
                tx_sh    <= tx_data >> 1;
                last_q   <= last;
                busy     <= 1'b1;
                spi_nss  <= 1'b0;
                spi_sck  <= 1'b0;
                spi_mosi <= tx_data[0];
            end else begin
                case (state)
                    SPIM_LOW: begin
                        if (tick) begin
                            state   <= SPIM_HIGH;
                            spi_sck <= 1'b1;
                        end
                    end
                    SPIM_HIGH: begin
                        rx_sh <= rx_next;
                        if (tick) begin
                            spi_sck <= 1'b0;
                            if (idx != IW'(BYTE_WIDTH - 1)) begin
                                state    <= SPIM_LOW;
                                idx      <= idx + IW'(1);
                                spi_mosi <= tx_sh[0];
                                tx_sh    <= tx_sh >> 1;
                            end else begin
                                state   <= SPIM_END;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                rx_data <= rx_next;
                                spi_nss <= last_q;
                            end
                        end
                    end
                    SPIM_END:  state <= last_q ? SPIM_IDLE : SPIM_HOLD;
                    SPIM_IDLE: state <= SPIM_IDLE;
                    SPIM_HOLD: state <= SPIM_HOLD;
                    default:   state <= SPIM_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: randomized self-checking bench for spi_byte_master against a byte-level loopback model
module tb_spi_byte_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       last = 1'b0;
    logic [7:0] tx_data = '0;
    logic       busy, done, nss, sck, mosi, miso;
    logic [7:0] rx_data;

    logic       s1_start = 1'b0;
    logic       s1_last = 1'b1;
    logic [7:0] s1_tx = '0;
    logic       s1_busy, s1_done, s1_nss, s1_sck, s1_mosi;
    logic [7:0] s1_rx;

    int n_checks = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int nss_rises = 0;
    int mosi_viol = 0;
    logic sck_p = 1'b0;
    logic mosi_p = 1'b0;
    logic mosi_q[$];

    always #5 clk = ~clk;

    assign miso = ~mosi;

    spi_byte_master #(.CLK_DIV(2), .BYTE_WIDTH(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .last(last), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .spi_nss(nss), .spi_sck(sck), .spi_mosi(mosi), .spi_miso(miso)
    );

    spi_byte_master #(.CLK_DIV(1), .BYTE_WIDTH(8)) u_dut1 (
        .clk(clk), .reset(reset), .start(s1_start), .last(s1_last), .tx_data(s1_tx),
        .busy(s1_busy), .done(s1_done), .rx_data(s1_rx),
        .spi_nss(s1_nss), .spi_sck(s1_sck), .spi_mosi(s1_mosi), .spi_miso(1'b1)
    );

    always @(posedge clk) if (done === 1'b1) done_cnt++;
    always @(posedge nss) nss_rises++;
    always @(posedge sck) mosi_q.push_back(mosi);
    always @(negedge clk) begin
        if (sck_p === 1'b1 && sck === 1'b1 && mosi !== mosi_p) mosi_viol++;
        sck_p = sck;
        mosi_p = mosi;
    end

    // Issues one byte from a negedge and returns the cycle (1 = first cycle after the
    // accepting edge) in which done was seen, 0 on timeout. Returns at that negedge.
    task automatic xfer(input logic [7:0] tx, input logic lst, output int cyc,
                        output logic [7:0] rx, output logic nss_d, output logic [2:0] c1,
                        output logic [7:0] sent);
        mosi_q.delete();
        start = 1'b1;
        tx_data = tx;
        last = lst;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        c1 = 'x;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) c1 = {busy, nss, mosi};
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        rx = rx_data;
        nss_d = nss;
        sent = 'x;
        if (mosi_q.size() == 8) for (int k = 0; k < 8; k++) sent[k] = mosi_q[k];
    endtask

    task automatic test_reset;
        int dc;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({nss, sck, mosi, busy, done, rx_data} !== {5'b10000, 8'h00}) $display("FAIL reset_values got %b%b%b%b%b rx=%h want 10000 rx=00", nss, sck, mosi, busy, done, rx_data);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        start = 1'b1;
        tx_data = 8'hA5;
        last = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(negedge clk);
        n_checks++;
        if ({sck, busy, nss} !== 3'b110) $display("FAIL reset_pre_midbyte sck/busy/nss=%b want 110", {sck, busy, nss});
        else n_pass++;
        dc = done_cnt;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({nss, sck, busy} !== 3'b100) $display("FAIL reset_midbyte nss/sck/busy=%b want 100", {nss, sck, busy});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++;
        if (done_cnt != dc || rx_data !== 8'h00 || nss !== 1'b1) $display("FAIL reset_no_done dones=%0d rx=%h nss=%b want 0 00 1", done_cnt - dc, rx_data, nss);
        else n_pass++;
    endtask

    task automatic test_single;
        int cyc;
        logic [7:0] rx, sent;
        logic nss_d;
        logic [2:0] c1;
        xfer(8'h29, 1'b1, cyc, rx, nss_d, c1, sent);
        n_checks++;
        if (cyc != 33) $display("FAIL single_done_cycle got %0d want 33", cyc);
        else n_pass++;
        n_checks++;
        if (rx !== 8'hD6) $display("FAIL single_rx got %h want d6", rx);
        else n_pass++;
        n_checks++;
        if (nss_d !== 1'b1) $display("FAIL single_nss_at_done got %b want 1", nss_d);
        else n_pass++;
        n_checks++;
        if (sent !== 8'h29) $display("FAIL single_mosi_bits got %h want 29", sent);
        else n_pass++;
        n_checks++;
        if (c1 !== 3'b101) $display("FAIL single_first_cycle busy/nss/mosi=%b want 101", c1);
        else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_burst;
        logic [7:0] b[4] = '{8'h02, 8'h29, 8'h2A, 8'h32};
        int cyc, r0;
        logic [7:0] rx, sent;
        logic nss_d;
        logic [2:0] c1;
        r0 = nss_rises;
        for (int i = 0; i < 4; i++) begin
            xfer(b[i], i == 3, cyc, rx, nss_d, c1, sent);
            n_checks++;
            if (cyc != 33 || rx !== ~b[i] || sent !== b[i]) $display("FAIL burst_byte%0d cyc=%0d rx=%h sent=%h want 33 %h %h", i, cyc, rx, sent, ~b[i], b[i]);
            else n_pass++;
        end
        n_checks++;
        if (nss_rises - r0 != 1 || nss !== 1'b1) $display("FAIL burst_nss_rises got %0d nss=%b want 1 1", nss_rises - r0, nss);
        else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_busy_ignore;
        int dc, cyc;
        dc = done_cnt;
        mosi_q.delete();
        start = 1'b1;
        tx_data = 8'h00;
        last = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 10) begin
                start = 1'b1;
                tx_data = 8'hFF;
                last = 1'b0;
            end
            if (i == 11) start = 1'b0;
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        n_checks++;
        if (cyc != 33 || rx_data !== 8'hFF) $display("FAIL busy_ignore_rx cyc=%0d rx=%h want 33 ff", cyc, rx_data);
        else n_pass++;
        repeat (60) @(negedge clk);
        n_checks++;
        if (done_cnt - dc != 1 || nss !== 1'b1 || mosi_q.size() != 8) $display("FAIL busy_ignore_second dones=%0d nss=%b bits=%0d want 1 1 8", done_cnt - dc, nss, mosi_q.size());
        else n_pass++;
    endtask

    task automatic test_hold;
        int cyc, bad;
        logic [7:0] rx, sent, t;
        logic nss_d;
        logic [2:0] c1;
        t = 8'($urandom);
        xfer(t, 1'b0, cyc, rx, nss_d, c1, sent);
        n_checks++;
        if (cyc != 33 || rx !== ~t || nss_d !== 1'b0) $display("FAIL hold_first cyc=%0d rx=%h nss=%b want 33 %h 0", cyc, rx, nss_d, ~t);
        else n_pass++;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (nss !== 1'b0 || sck !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL hold_idle bad_cycles=%0d want 0", bad);
        else n_pass++;
        xfer(8'h91, 1'b1, cyc, rx, nss_d, c1, sent);
        n_checks++;
        if (cyc != 33 || rx !== 8'h6E || nss_d !== 1'b1) $display("FAIL hold_release cyc=%0d rx=%h nss=%b want 33 6e 1", cyc, rx, nss_d);
        else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random;
        int cyc;
        logic [7:0] rx, sent, t;
        logic nss_d, l;
        logic [2:0] c1;
        for (int i = 0; i < 10; i++) begin
            t = 8'($urandom);
            l = (i == 9) ? 1'b1 : 1'($urandom_range(0, 1));
            xfer(t, l, cyc, rx, nss_d, c1, sent);
            n_checks++;
            if (cyc != 33 || rx !== ~t || sent !== t || nss_d !== l || c1 !== {2'b10, t[0]}) $display("FAIL random_byte%0d cyc=%0d rx=%h sent=%h nss=%b c1=%b want 33 %h %h %b %b", i, cyc, rx, sent, nss_d, c1, ~t, t, l, {2'b10, t[0]});
            else n_pass++;
            if (l && $urandom_range(0, 1) == 1) repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_div1;
        int cyc;
        s1_tx = 8'($urandom);
        s1_start = 1'b1;
        @(posedge clk);
        #1 s1_start = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (s1_done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        n_checks++;
        if (cyc != 17 || s1_rx !== 8'hFF || s1_nss !== 1'b1) $display("FAIL div1 cyc=%0d rx=%h nss=%b want 17 ff 1", cyc, s1_rx, s1_nss);
        else n_pass++;
    endtask

    task automatic test_mosi_stable;
        n_checks++;
        if (mosi_viol != 0) $display("FAIL mosi_stable changes_while_sck_high=%0d want 0", mosi_viol);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst;
        test_busy_ignore;
        test_hold;
        test_random;
        test_div1;
        test_mosi_stable;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
